// File: rtl/apb_modport_if.sv
// Command-side bundle for the APB two-slave endpoint: transfer request, command fields and read-back data.
// The initiator drives commands through the master modport; apb_modport consumes them through the slave modport.
interface apb_modport_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
);
  logic                  transfer;
  logic                  READ_WRITE;
  logic [ADDR_WIDTH-1:0] apb_write_paddr;
  logic [DATA_WIDTH-1:0] apb_write_data;
  logic [ADDR_WIDTH-1:0] apb_read_paddr;
  logic [DATA_WIDTH-1:0] apb_read_data_out;

  modport master (
    output transfer,
    output READ_WRITE,
    output apb_write_paddr,
    output apb_write_data,
    output apb_read_paddr,
    input  apb_read_data_out
  );

  modport slave (
    input  transfer,
    input  READ_WRITE,
    input  apb_write_paddr,
    input  apb_write_data,
    input  apb_read_paddr,
    output apb_read_data_out
  );
endinterface

// File: rtl/apb_modport.sv
// APB bridge plus two 256x8 register slaves; address MSB selects the slave, 2 cycles per transfer.
// Optional macro APB_WAIT_STATE_EN: slave2 inserts one wait state, so its transfers take 3 cycles.
module apb_modport_slave #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int DEPTH   = 256,
  parameter bit WAIT_EN = 1'b0
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready
);
  logic [DW-1:0] mem [DEPTH];

  generate
    if (WAIT_EN) begin : g_wait
      // Low on the first ACCESS cycle, high on the second.
      logic waited;

      always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
          waited <= 1'b0;
        end else if (psel && penable && !waited) begin
          waited <= 1'b1;
        end else begin
          waited <= 1'b0;
        end
      end

      assign pready = waited;
    end else begin : g_nowait
      assign pready = 1'b1;
    end
  endgenerate

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (psel && penable && pwrite && pready) begin
      mem[paddr] <= pwdata;
    end
  end

  assign prdata = mem[paddr];
endmodule

module apb_modport #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic         pclk,
  input  logic         presetn,
  apb_modport_if.slave bus
);
`ifdef APB_WAIT_STATE_EN
  localparam bit SLAVE2_WAIT = 1'b1;
`else
  localparam bit SLAVE2_WAIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  psel1;
  logic                  psel2;
  logic                  penable;
  logic                  pwrite;
  logic                  pready;
  logic                  pready1;
  logic                  pready2;
  logic [DATA_WIDTH-1:0] prdata;
  logic [DATA_WIDTH-1:0] prdata1;
  logic [DATA_WIDTH-1:0] prdata2;
  logic                  capture;
  logic                  done;

  assign pready = paddr_q[ADDR_WIDTH-1] ? pready2 : pready1;
  assign prdata = paddr_q[ADDR_WIDTH-1] ? prdata2 : prdata1;
  assign done   = (state == ACCESS) && pready;
  // A new command is taken from IDLE or straight out of a completing ACCESS.
  assign capture = bus.transfer && ((state == IDLE) || done);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.transfer ? SETUP : IDLE;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        if (pready) begin
          state_nxt = bus.transfer ? SETUP : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psel1   = 1'b0;
    psel2   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    if ((state == SETUP) || (state == ACCESS)) begin
      psel1   = ~paddr_q[ADDR_WIDTH-1];
      psel2   = paddr_q[ADDR_WIDTH-1];
      penable = (state == ACCESS);
      pwrite  = ~rw_q;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rw_q     <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else if (capture) begin
      rw_q <= bus.READ_WRITE;
      if (bus.READ_WRITE) begin
        paddr_q <= bus.apb_read_paddr;
      end else begin
        paddr_q  <= bus.apb_write_paddr;
        pwdata_q <= bus.apb_write_data;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rdata_q <= '0;
    end else if (done && rw_q) begin
      rdata_q <= prdata;
    end
  end

  assign bus.apb_read_data_out = rdata_q;

  apb_modport_slave #(
    .AW      (ADDR_WIDTH - 1),
    .DW      (DATA_WIDTH),
    .DEPTH   (MEM_DEPTH),
    .WAIT_EN (1'b0)
  ) u_slave1 (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel1),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr_q[ADDR_WIDTH-2:0]),
    .pwdata  (pwdata_q),
    .prdata  (prdata1),
    .pready  (pready1)
  );

  apb_modport_slave #(
    .AW      (ADDR_WIDTH - 1),
    .DW      (DATA_WIDTH),
    .DEPTH   (MEM_DEPTH),
    .WAIT_EN (SLAVE2_WAIT)
  ) u_slave2 (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel2),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr_q[ADDR_WIDTH-2:0]),
    .pwdata  (pwdata_q),
    .prdata  (prdata2),
    .pready  (pready2)
  );
endmodule

// File: tb/tb_apb_modport.sv
// Directed bench for apb_modport: vector table of single transfers, then back-to-back and mid-transfer reset sequences.
module tb_apb_modport;
`ifdef APB_WAIT_STATE_EN
  localparam bit WS = 1'b1;
`else
  localparam bit WS = 1'b0;
`endif

  logic pclk;
  logic presetn;

  apb_modport_if #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) bus ();

  apb_modport #(.ADDR_WIDTH(9), .DATA_WIDTH(8), .MEM_DEPTH(256)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    bit         rw;
    logic [8:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [12];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] cur_exp = 8'h00;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic int cycles(input logic [8:0] addr);
    return (WS && addr[8]) ? 3 : 2;
  endfunction

  task automatic drive_cmd(input bit rw, input logic [8:0] addr, input logic [7:0] wd);
    bus.READ_WRITE = rw;
    if (rw) begin
      bus.apb_read_paddr  = addr;
      bus.apb_write_paddr = addr ^ 9'h0AA;
      bus.apb_write_data  = ~wd;
    end else begin
      bus.apb_write_paddr = addr;
      bus.apb_write_data  = wd;
      bus.apb_read_paddr  = addr ^ 9'h0AA;
    end
  endtask

  // Entered and left 1 time unit after a rising edge with the DUT idle.
  task automatic do_cmd(input bit rw, input logic [8:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp, input string name);
    int n;
    n = cycles(addr);
    bus.transfer = 1'b1;
    drive_cmd(rw, addr, wd);
    @(posedge pclk); #1;
    bus.transfer = 1'b0;
    drive_cmd(~rw, addr ^ 9'h155, ~wd);
    repeat (n - 1) @(posedge pclk);
    #1;
    chk({name, "_early"}, bus.apb_read_data_out, cur_exp);
    @(posedge pclk); #1;
    if (rw) cur_exp = exp;
    chk(name, bus.apb_read_data_out, cur_exp);
  endtask

  bit         b_rw   [4];
  logic [8:0] b_addr [4];
  logic [7:0] b_dat  [4];

  initial begin
    vecs[0]  = '{1'b1, 9'h005, 8'h00, 8'h00};
    vecs[1]  = '{1'b0, 9'h005, 8'hA5, 8'h00};
    vecs[2]  = '{1'b1, 9'h005, 8'h00, 8'hA5};
    vecs[3]  = '{1'b0, 9'h105, 8'h3C, 8'h00};
    vecs[4]  = '{1'b1, 9'h005, 8'h00, 8'hA5};
    vecs[5]  = '{1'b1, 9'h105, 8'h00, 8'h3C};
    vecs[6]  = '{1'b1, 9'h0FF, 8'h00, 8'h00};
    vecs[7]  = '{1'b0, 9'h000, 8'h11, 8'h00};
    vecs[8]  = '{1'b1, 9'h000, 8'h00, 8'h11};
    vecs[9]  = '{1'b0, 9'h100, 8'h22, 8'h00};
    vecs[10] = '{1'b1, 9'h100, 8'h00, 8'h22};
    vecs[11] = '{1'b1, 9'h000, 8'h00, 8'h11};

    b_rw[0] = 1'b0; b_addr[0] = 9'h0FF; b_dat[0] = 8'hF0;
    b_rw[1] = 1'b1; b_addr[1] = 9'h0FF; b_dat[1] = 8'hF0;
    b_rw[2] = 1'b0; b_addr[2] = 9'h1FF; b_dat[2] = 8'h0F;
    b_rw[3] = 1'b1; b_addr[3] = 9'h1FF; b_dat[3] = 8'h0F;

    presetn             = 1'b0;
    bus.transfer        = 1'b0;
    bus.READ_WRITE      = 1'b0;
    bus.apb_write_paddr = '0;
    bus.apb_write_data  = '0;
    bus.apb_read_paddr  = '0;
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    chk("reset_out", bus.apb_read_data_out, 8'h00);
    repeat (3) @(posedge pclk);
    #1;
    chk("idle_out", bus.apb_read_data_out, 8'h00);

    for (int i = 0; i < 12; i++) begin
      do_cmd(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Back-to-back: transfer held high, a new command is captured at each completion edge.
    bus.transfer = 1'b1;
    drive_cmd(b_rw[0], b_addr[0], b_dat[0]);
    @(posedge pclk); #1;
    for (int i = 1; i <= 4; i++) begin
      if (i < 4) begin
        drive_cmd(b_rw[i], b_addr[i], b_dat[i]);
      end else begin
        bus.transfer = 1'b0;
        drive_cmd(1'b1, 9'h0AA, 8'h99);
      end
      repeat (cycles(b_addr[i-1]) - 1) @(posedge pclk);
      @(posedge pclk); #1;
      if (b_rw[i-1]) cur_exp = b_dat[i-1];
      chk($sformatf("b2b%0d", i - 1), bus.apb_read_data_out, cur_exp);
    end
    do_cmd(1'b1, 9'h0FF, 8'h00, 8'hF0, "b2b_reread_lo");
    do_cmd(1'b1, 9'h1FF, 8'h00, 8'h0F, "b2b_reread_hi");

    // Reset during ACCESS of a write.
    bus.transfer = 1'b1;
    drive_cmd(1'b0, 9'h010, 8'h55);
    @(posedge pclk); #1;
    bus.transfer = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    chk("rst_mid_out", bus.apb_read_data_out, 8'h00);
    cur_exp = 8'h00;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    chk("rst_hold_out", bus.apb_read_data_out, 8'h00);
    do_cmd(1'b1, 9'h010, 8'h00, 8'h00, "rst_rd_010");
    do_cmd(1'b1, 9'h105, 8'h00, 8'h00, "rst_rd_105");
    do_cmd(1'b0, 9'h010, 8'h66, 8'h00, "post_wr_010");
    do_cmd(1'b1, 9'h010, 8'h00, 8'h66, "post_rd_010");
    do_cmd(1'b1, 9'h110, 8'h00, 8'h00, "post_rd_110");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
